// File: rtl/fft_addr_gen.sv
// Radix-2 in-place FFT address generator: walks every stage's butterflies and
// issues operand address pairs plus twiddle index, with optional inter-stage idle gap.
module fft_addr_gen #(
    parameter int unsigned FFT_POINTS = 1024,
    parameter int unsigned STAGE_GAP  = 4
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        start,
    input  logic                                        out_ready,
    output logic                                        out_valid,
    output logic [$clog2(FFT_POINTS)-1:0]               addr_a,
    output logic [$clog2(FFT_POINTS)-1:0]               addr_b,
    output logic [$clog2(FFT_POINTS)-1:0]               tw_index,
    output logic [$clog2($clog2(FFT_POINTS)+1)-1:0]     stage,
    output logic                                        busy,
    output logic                                        done
);

    localparam int unsigned L  = $clog2(FFT_POINTS);
    localparam int unsigned SW = $clog2(L + 1);
    localparam int unsigned GW = 4;

    localparam logic [L-1:0]  J_LAST = L'(FFT_POINTS / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(L - 1);
    localparam logic [GW-1:0] G_LAST = GW'(STAGE_GAP - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        GAP    = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [L-1:0]    j_q, j_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [SW-1:0]   stage_d;
    logic            valid_d, busy_d, done_d, load;
    logic [L-1:0]    mask, lo, a_nxt, b_nxt, tw_nxt;

    // Next-state and next-output selection; load marks a new address set.
    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        gap_d   = gap_q;
        stage_d = stage;
        valid_d = 1'b0;
        done_d  = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    j_d     = '0;
                    stage_d = '0;
                    valid_d = 1'b1;
                    load    = 1'b1;
                end
            end
            RUN: begin
                valid_d = 1'b1;
                if (out_valid && out_ready) begin
                    if (j_q == J_LAST) begin
                        j_d = '0;
                        if (stage == S_LAST) begin
                            state_d = FINISH;
                            valid_d = 1'b0;
                            done_d  = 1'b1;
                        end else if (STAGE_GAP == 0) begin
                            stage_d = stage + SW'(1);
                            load    = 1'b1;
                        end else begin
                            state_d = GAP;
                            gap_d   = '0;
                            valid_d = 1'b0;
                        end
                    end else begin
                        j_d  = j_q + L'(1);
                        load = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_q == G_LAST) begin
                    state_d = RUN;
                    gap_d   = '0;
                    stage_d = stage + SW'(1);
                    valid_d = 1'b1;
                    load    = 1'b1;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Butterfly addressing: insert a zero bit at position stage into j.
    always_comb begin
        mask   = (L'(1) << stage_d) - L'(1);
        lo     = j_d & mask;
        a_nxt  = ((j_d & ~mask) << 1) | lo;
        b_nxt  = a_nxt | (L'(1) << stage_d);
        tw_nxt = lo << (S_LAST - stage_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            j_q       <= '0;
            gap_q     <= '0;
            stage     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            addr_a    <= '0;
            addr_b    <= '0;
            tw_index  <= '0;
        end else begin
            state_q   <= state_d;
            j_q       <= j_d;
            gap_q     <= gap_d;
            stage     <= stage_d;
            out_valid <= valid_d;
            busy      <= busy_d;
            done      <= done_d;
            if (load) begin
                addr_a   <= a_nxt;
                addr_b   <= b_nxt;
                tw_index <= tw_nxt;
            end
        end
    end

endmodule

// File: tb/tb_fft_addr_gen.sv
// Bench for fft_addr_gen: three instances (8-pt no gap, 8-pt gap 3, 1024-pt no gap)
// checked every cycle against a pass-level arithmetic model of the address sequence.
module tb_fft_addr_gen;

    logic clk;
    logic rst_n;
    logic s0, s1, sk, r8, rk;

    logic       v0, bz0, d0, v1, bz1, d1, vk, bzk, dk;
    logic [2:0] a0, b0, t0, a1, b1, t1;
    logic [1:0] st0, st1;
    logic [9:0] ak, bk, tk;
    logic [3:0] stk;

    int errors = 0;
    int checks = 0;

    fft_addr_gen #(.FFT_POINTS(8), .STAGE_GAP(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(s0), .out_ready(r8), .out_valid(v0),
        .addr_a(a0), .addr_b(b0), .tw_index(t0), .stage(st0), .busy(bz0), .done(d0));
    fft_addr_gen #(.FFT_POINTS(8), .STAGE_GAP(3)) u1 (
        .clk(clk), .rst_n(rst_n), .start(s1), .out_ready(r8), .out_valid(v1),
        .addr_a(a1), .addr_b(b1), .tw_index(t1), .stage(st1), .busy(bz1), .done(d1));
    fft_addr_gen #(.FFT_POINTS(1024), .STAGE_GAP(0)) uk (
        .clk(clk), .rst_n(rst_n), .start(sk), .out_ready(rk), .out_valid(vk),
        .addr_a(ak), .addr_b(bk), .tw_index(tk), .stage(stk), .busy(bzk), .done(dk));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-computed 8-point sequence (addr_a, addr_b, tw_index) per transfer.
    int lit_a [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int lit_b [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int lit_t [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    // Per-instance model state.
    bit act [3], fin [3], pstall [3];
    int idx [3], gl [3], bub [3], xf [3], npass [3];
    int pa [3], pb [3], pt [3], ps [3];
    bit cov [3][1024];

    task automatic chk(input string nm, input int act_v, input int exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act_v, exp_v);
        end
    endtask

    // Transfer k of a pass: stage = k / (N/2), j = k mod (N/2).
    function automatic void model(input int n, input int k,
                                  output int a, output int b, output int t, output int s);
        int h, j;
        s = k / (n / 2);
        j = k % (n / 2);
        h = 1 << s;
        a = (j / h) * 2 * h + j % h;
        b = a + h;
        t = (j % h) * ((n / 2) / h);
    endfunction

    task automatic mon(input int id, input int n, input int gap, input int exp_bub,
                       input int exp_xf, input logic st_i, input logic rdy,
                       input logic v, input logic dn, input logic bz,
                       input int a, input int b, input int t, input int sg);
        int ea, eb, et, es, half, tot, j, cnt;
        bit ev;
        half = n / 2;
        tot  = half * $clog2(n);
        if (!rst_n) begin
            chk($sformatf("u%0d rst out_valid", id), int'(v), 0);
            chk($sformatf("u%0d rst done", id), int'(dn), 0);
            chk($sformatf("u%0d rst busy", id), int'(bz), 0);
            chk($sformatf("u%0d rst addr_a", id), a, 0);
            chk($sformatf("u%0d rst addr_b", id), b, 0);
            chk($sformatf("u%0d rst tw_index", id), t, 0);
            chk($sformatf("u%0d rst stage", id), sg, 0);
            act[id] = 0; fin[id] = 0; idx[id] = 0; gl[id] = 0;
            pstall[id] = 0; bub[id] = 0; xf[id] = 0;
            return;
        end
        ev = act[id] && gl[id] == 0 && !fin[id];
        chk($sformatf("u%0d out_valid", id), int'(v), int'(ev));
        chk($sformatf("u%0d done", id), int'(dn), int'(fin[id]));
        chk($sformatf("u%0d busy", id), int'(bz), int'(act[id] || fin[id]));
        if (pstall[id] && v) begin
            chk($sformatf("u%0d hold addr_a", id), a, pa[id]);
            chk($sformatf("u%0d hold addr_b", id), b, pb[id]);
            chk($sformatf("u%0d hold tw_index", id), t, pt[id]);
            chk($sformatf("u%0d hold stage", id), sg, ps[id]);
        end
        if (ev) begin
            model(n, idx[id], ea, eb, et, es);
            chk($sformatf("u%0d addr_a k=%0d", id, idx[id]), a, ea);
            chk($sformatf("u%0d addr_b k=%0d", id, idx[id]), b, eb);
            chk($sformatf("u%0d tw_index k=%0d", id, idx[id]), t, et);
            chk($sformatf("u%0d stage k=%0d", id, idx[id]), sg, es);
            chk($sformatf("u%0d tw_index range", id), int'(t < half), 1);
            if (n == 8 && idx[id] < 12) begin
                chk($sformatf("u%0d literal addr_a k=%0d", id, idx[id]), a, lit_a[idx[id]]);
                chk($sformatf("u%0d literal addr_b k=%0d", id, idx[id]), b, lit_b[idx[id]]);
                chk($sformatf("u%0d literal tw k=%0d", id, idx[id]), t, lit_t[idx[id]]);
            end
        end
        if (act[id] && !v) bub[id]++;
        if (v && rdy) xf[id]++;
        pstall[id] = v && !rdy;
        pa[id] = a; pb[id] = b; pt[id] = t; ps[id] = sg;

        if (fin[id]) begin
            fin[id] = 0;
            npass[id]++;
            chk($sformatf("u%0d transfers per pass", id), xf[id], exp_xf);
        end else if (!act[id]) begin
            if (st_i) begin
                act[id] = 1; idx[id] = 0; gl[id] = 0; bub[id] = 0; xf[id] = 0;
            end
        end else if (gl[id] > 0) begin
            gl[id]--;
        end else if (rdy) begin
            j = idx[id] % half;
            if (j == 0)
                for (int i = 0; i < 1024; i++) cov[id][i] = 1'b0;
            chk($sformatf("u%0d coverage dup a=%0d", id, a), int'(cov[id][a]), 0);
            cov[id][a] = 1'b1;
            chk($sformatf("u%0d coverage dup b=%0d", id, b), int'(cov[id][b]), 0);
            cov[id][b] = 1'b1;
            if (j == half - 1) begin
                cnt = 0;
                for (int i = 0; i < n; i++) cnt += int'(cov[id][i]);
                chk($sformatf("u%0d stage coverage", id), cnt, n);
            end
            idx[id]++;
            if (idx[id] == tot) begin
                act[id] = 0;
                fin[id] = 1;
                chk($sformatf("u%0d bubble cycles", id), bub[id], exp_bub);
            end else if (idx[id] % half == 0) begin
                gl[id] = gap;
            end
        end
    endtask

    // Single compare process for all three instances.
    always @(negedge clk) begin
        mon(0, 8, 0, 0, 12, s0, r8, v0, d0, bz0, int'(a0), int'(b0), int'(t0), int'(st0));
        mon(1, 8, 3, 6, 12, s1, r8, v1, d1, bz1, int'(a1), int'(b1), int'(t1), int'(st1));
        mon(2, 1024, 0, 0, 5120, sk, rk, vk, dk, bzk, int'(ak), int'(bk), int'(tk), int'(stk));
    end

    initial begin
        int ea, eb, et, es;
        rst_n = 1'b0;
        s0 = 1'b0; s1 = 1'b0; sk = 1'b0; r8 = 1'b0; rk = 1'b0;

        // Pin the model against hand-computed values.
        for (int k = 0; k < 12; k++) begin
            model(8, k, ea, eb, et, es);
            chk($sformatf("model8 a k=%0d", k), ea, lit_a[k]);
            chk($sformatf("model8 b k=%0d", k), eb, lit_b[k]);
            chk($sformatf("model8 t k=%0d", k), et, lit_t[k]);
        end
        model(1024, 9 * 512 + 5, ea, eb, et, es);
        chk("model1k s9j5 a", ea, 5);
        chk("model1k s9j5 b", eb, 517);
        chk("model1k s9j5 t", et, 5);
        model(1024, 3 * 512 + 13, ea, eb, et, es);
        chk("model1k s3j13 a", ea, 21);
        chk("model1k s3j13 b", eb, 29);
        chk("model1k s3j13 t", et, 320);
        chk("model1k s3j13 s", es, 3);

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Clean 8-point passes with full throughput.
        @(posedge clk); #1 r8 = 1'b1; s0 = 1'b1; s1 = 1'b1;
        @(posedge clk); #1 s0 = 1'b0; s1 = 1'b0;
        for (int c = 0; c < 100 && npass[1] < 1; c++) begin
            @(posedge clk); #1;
        end
        chk("u0 first pass complete", npass[0], 1);
        chk("u1 first pass complete", npass[1], 1);

        // Backpressure plus stray starts in RUN and in the done cycle.
        repeat (2) @(posedge clk);
        #1 s0 = 1'b1; s1 = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 200; c++) begin
            r8 = ($urandom_range(0, 2) != 0);
            s0 = (c == 4) || (c == 9) || d0;
            s1 = (c == 4) || (c == 15) || d1;
            @(posedge clk); #1;
        end
        s0 = 1'b0; s1 = 1'b0;
        chk("u0 no restart", npass[0], 2);
        chk("u1 no restart", npass[1], 2);

        // 1024-point pass under random backpressure.
        sk = 1'b1;
        @(posedge clk); #1 sk = 1'b0;
        for (int c = 0; c < 20000 && npass[2] < 1; c++) begin
            rk = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        chk("uk pass complete", npass[2], 1);

        // Second pass abandoned by asynchronous reset during stage 3.
        rk = 1'b0;
        repeat (2) @(posedge clk);
        #1 sk = 1'b1;
        @(posedge clk); #1 sk = 1'b0;
        for (int c = 0; c < 8000 && !(stk == 4'd3 && xf[2] > 3 * 512 + 100); c++) begin
            rk = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        chk("uk reached stage 3", int'(stk), 3);
        #1 rst_n = 1'b0;
        #1;
        chk("async rst out_valid", int'(vk), 0);
        chk("async rst addr_a", int'(ak), 0);
        chk("async rst addr_b", int'(bk), 0);
        chk("async rst tw_index", int'(tk), 0);
        chk("async rst stage", int'(stk), 0);
        chk("async rst busy", int'(bzk), 0);
        chk("async rst done", int'(dk), 0);
        @(posedge clk); #2 rst_n = 1'b1;
        chk("no done from abandoned pass", npass[2], 1);

        // Fresh pass after reset must restart from stage 0, j 0.
        @(posedge clk); #1 rk = 1'b1; sk = 1'b1;
        @(posedge clk); #1 sk = 1'b0;
        for (int c = 0; c < 6000 && npass[2] < 2; c++) begin
            @(posedge clk); #1;
        end
        chk("uk pass after reset complete", npass[2], 2);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fft_addr_gen.md
FFT_ADDR_GEN -- requirements
Module: fft_addr_gen

Interface
REQ-001 SHALL have parameter FFT_POINTS, default 1024, FFT size; power of 2, at least 4; L = log2(FFT_POINTS).
REQ-002 SHALL have parameter STAGE_GAP, default 4, idle cycles inserted between stages for butterfly pipeline write-back; legal range 0..15.
REQ-003 SHALL have port clk, input, 1 bit, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit, single-cycle request to begin one full FFT pass.
REQ-006 SHALL have port out_ready, input, 1 bit, butterfly datapath accepts the current address set.
REQ-007 SHALL have port out_valid, output, 1 bit, addr_a/addr_b/tw_index/stage are valid.
REQ-008 SHALL have port addr_a, output, L bits, upper-butterfly operand address.
REQ-009 SHALL have port addr_b, output, L bits, lower-butterfly operand address.
REQ-010 SHALL have port tw_index, output, L bits, twiddle index for the twiddle LUT; always < FFT_POINTS/2.
REQ-011 SHALL have port stage, output, ceil(log2(L+1)) bits, current stage number 0..L-1.
REQ-012 SHALL have port busy, output, 1 bit, high from the cycle after an accepted start until done.
REQ-013 SHALL have port done, output, 1 bit, one-cycle pulse after the last butterfly of the last stage is accepted.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, GAP, FINISH; reset state IDLE.
REQ-015 IDLE: start=1 -> RUN, stage=0, butterfly counter j=0; start ignored in every other state.
REQ-016 RUN: out_valid=1; transfer occurs on out_valid&&out_ready; j increments by 1 per transfer only.
REQ-017 Address rule per stage s: half=2^s; addr_a = ((j>>s)<<(s+1)) | (j & (half-1)); addr_b = addr_a + half (equivalently addr_a | half); tw_index = (j & (half-1)) << (L-1-s).
REQ-018 All outputs SHALL be registered; out_valid first asserts the cycle after start is sampled.
REQ-019 While out_valid=1 and out_ready=0, addr_a, addr_b, tw_index and stage SHALL hold stable.
REQ-020 Transfer with j = FFT_POINTS/2-1 and s < L-1 -> GAP for exactly STAGE_GAP cycles with out_valid=0, then RUN with s+1, j=0; if STAGE_GAP=0, go directly to RUN with no bubble.
REQ-021 Transfer with j = FFT_POINTS/2-1 and s = L-1 -> FINISH: done=1 for one cycle, out_valid=0, then IDLE.
REQ-022 busy=1 in RUN, GAP and FINISH; busy=0 in IDLE.
REQ-023 Every pass SHALL issue exactly L*FFT_POINTS/2 transfers; each address in 0..FFT_POINTS-1 SHALL appear exactly once per stage across addr_a and addr_b.
REQ-024 start arriving together with done (FINISH cycle) SHALL be ignored; a new pass needs start while in IDLE.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, out_valid=0, done=0, busy=0, addr_a=0, addr_b=0, tw_index=0, stage=0, j=0, gap counter=0, regardless of clk.
REQ-026 Reset mid-pass SHALL abandon the pass with no done pulse; the first start after rst_n deasserts begins at stage 0, j=0.

Verification
REQ-027 FFT_POINTS=8, out_ready=1, STAGE_GAP=0, start pulse -> 12 consecutive transfers; stage 0: (0,1,0),(2,3,0),(4,5,0),(6,7,0); stage 1: (0,2,0),(1,3,2),(4,6,0),(5,7,2); stage 2: (0,4,0),(1,5,1),(2,6,2),(3,7,3) as (addr_a,addr_b,tw_index); done pulses the cycle after the 12th transfer.
REQ-028 FFT_POINTS=8, STAGE_GAP=3 -> exactly 3 cycles with out_valid=0 between stages 0 and 1 and between stages 1 and 2; 0 gap cycles after stage 2 before done.
REQ-029 Random out_ready backpressure, FFT_POINTS=1024 -> outputs stable while stalled; 5120 transfers total; per-stage address coverage check passes; tw_index < 512.
REQ-030 start pulsed during RUN and in the done cycle -> no restart and no change to the sequence; busy stays 1 until done.
REQ-031 rst_n asserted asynchronously mid-stage 3 -> outputs zero before the next clk edge; no done pulse; next start produces stage 0, j=0 sequence.
